// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: decode/execute/memory hazard inputs and the
// stall/flush/debug outputs. The core side uses master; the controller uses slave.
interface pipeline_hazard_controller_if #(
  parameter int unsigned COUNTER_WIDTH = 16
);
  logic [4:0]               rs1_decode;
  logic [4:0]               rs2_decode;
  logic                     rs1_used_decode;
  logic                     rs2_used_decode;
  logic [4:0]               rd_execute;
  logic                     memRead_execute;
  logic [1:0]               next_PC_select_execute;
  logic                     memReq_memory;
  logic                     mem_ready;
  logic                     stall_fetch;
  logic                     stall_decode;
  logic                     hold_execute_memory;
  logic                     flush_decode;
  logic [1:0]               ctrl_state;
  logic [COUNTER_WIDTH-1:0] stall_cycle_count;
  logic [COUNTER_WIDTH-1:0] flush_cycle_count;

  modport master (
    output rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
           rd_execute, memRead_execute, next_PC_select_execute,
           memReq_memory, mem_ready,
    input  stall_fetch, stall_decode, hold_execute_memory, flush_decode,
           ctrl_state, stall_cycle_count, flush_cycle_count
  );

  modport slave (
    input  rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
           rd_execute, memRead_execute, next_PC_select_execute,
           memReq_memory, mem_ready,
    output stall_fetch, stall_decode, hold_execute_memory, flush_decode,
           ctrl_state, stall_cycle_count, flush_cycle_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, memory-wait holds,
// multi-cycle flushes after redirects, plus saturating stall/flush cycle counters.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  pipeline_hazard_controller_if.slave       hz
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [2:0] RELOAD   = 3'(FLUSH_CYCLES - 1);

  logic [1:0]               state, state_next;
  logic [2:0]               fcnt, fcnt_next;
  logic                     lu, mw, redirect;
  logic                     stall_c, hold_c, flush_c;
  logic [COUNTER_WIDTH-1:0] stall_count, flush_count;

  assign lu = hz.memRead_execute && (hz.rd_execute != 5'd0) &&
              ((hz.rs1_used_decode && (hz.rs1_decode == hz.rd_execute)) ||
               (hz.rs2_used_decode && (hz.rs2_decode == hz.rd_execute)));
  assign mw       = hz.memReq_memory && !hz.mem_ready;
  assign redirect = hz.next_PC_select_execute != 2'd0;

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    stall_c    = 1'b0;
    hold_c     = 1'b0;
    flush_c    = 1'b0;
    case (state)
      RUN: begin
        if (mw) begin
          stall_c    = 1'b1;
          hold_c     = 1'b1;
          state_next = MEM_WAIT;
        end else if (redirect) begin
          // Flush outranks load-use, so fetch is not held and the new PC loads.
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            fcnt_next  = RELOAD;
          end
        end else if (lu) begin
          stall_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall_c = 1'b1;
        hold_c  = 1'b1;
        if (hz.mem_ready) state_next = RUN;
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (mw) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
        end else if (redirect) begin
          fcnt_next = RELOAD;
        end else if (fcnt <= 3'd1) begin
          state_next = RUN;
          fcnt_next  = 3'd0;
        end else begin
          fcnt_next = fcnt - 3'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      fcnt        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
      if (stall_c && (stall_count != '1)) stall_count <= stall_count + COUNTER_WIDTH'(1);
      if (flush_c && (flush_count != '1)) flush_count <= flush_count + COUNTER_WIDTH'(1);
    end
  end

  assign hz.stall_fetch         = reset & stall_c;
  assign hz.stall_decode        = reset & stall_c;
  assign hz.hold_execute_memory = reset & hold_c;
  assign hz.flush_decode        = reset & flush_c;
  assign hz.ctrl_state          = state;
  assign hz.stall_cycle_count   = stall_count;
  assign hz.flush_cycle_count   = flush_count;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: expected outputs are queued
// as each cycle is driven and compared on the following falling edge.
module tb_pipeline_hazard_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_hazard_controller_if #(.COUNTER_WIDTH(16)) h_if ();
  pipeline_hazard_controller_if #(.COUNTER_WIDTH(4))  s_if ();

  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .hz(h_if.slave));
  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .COUNTER_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .hz(s_if.slave));

  typedef struct {
    logic        stall;
    logic        hold;
    logic        flush;
    logic [1:0]  st;
    int unsigned scnt;
    int unsigned fcnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_scnt = 0;
  int unsigned exp_fcnt = 0;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("stall_fetch",  64'(h_if.stall_fetch),         64'(e.stall));
      check_eq("stall_decode", 64'(h_if.stall_decode),        64'(e.stall));
      check_eq("hold_ex_mem",  64'(h_if.hold_execute_memory), 64'(e.hold));
      check_eq("flush_decode", 64'(h_if.flush_decode),        64'(e.flush));
      check_eq("ctrl_state",   64'(h_if.ctrl_state),          64'(e.st));
      check_eq("stall_count",  64'(h_if.stall_cycle_count),   64'(e.scnt));
      check_eq("flush_count",  64'(h_if.flush_cycle_count),   64'(e.fcnt));
    end
  end

  // One clock cycle of stimulus with the outputs expected during that cycle.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rde,
                      input logic mre, input logic [1:0] npc,
                      input logic mreq, input logic mrdy,
                      input logic es, input logic eh, input logic ef,
                      input logic [1:0] est);
    exp_t e;
    @(posedge clock); #1;
    h_if.rs1_decode = rs1;          h_if.rs2_decode = rs2;
    h_if.rs1_used_decode = u1;      h_if.rs2_used_decode = u2;
    h_if.rd_execute = rde;          h_if.memRead_execute = mre;
    h_if.next_PC_select_execute = npc;
    h_if.memReq_memory = mreq;      h_if.mem_ready = mrdy;
    e.stall = es; e.hold = eh; e.flush = ef; e.st = est;
    e.scnt = exp_scnt; e.fcnt = exp_fcnt;
    exp_q.push_back(e);
    if (es && exp_scnt < 65535) exp_scnt++;
    if (ef && exp_fcnt < 65535) exp_fcnt++;
  endtask

  task automatic idle(input logic es, input logic eh, input logic ef, input logic [1:0] est);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, es, eh, ef, est);
  endtask

  task automatic drain;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    check_eq("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    h_if.rs1_decode = '0; h_if.rs2_decode = '0; h_if.rs1_used_decode = 1'b0;
    h_if.rs2_used_decode = 1'b0; h_if.rd_execute = '0; h_if.memRead_execute = 1'b0;
    h_if.next_PC_select_execute = '0; h_if.memReq_memory = 1'b0; h_if.mem_ready = 1'b0;
    s_if.rs1_decode = '0; s_if.rs2_decode = '0; s_if.rs1_used_decode = 1'b0;
    s_if.rs2_used_decode = 1'b0; s_if.rd_execute = '0; s_if.memRead_execute = 1'b0;
    s_if.next_PC_select_execute = '0; s_if.memReq_memory = 1'b0; s_if.mem_ready = 1'b0;

    #1 reset = 1'b0;
    #2;
    check_eq("reset_stall", 64'(h_if.stall_fetch), 64'd0);
    check_eq("reset_flush", 64'(h_if.flush_decode), 64'd0);
    check_eq("reset_state", 64'(h_if.ctrl_state), 64'd0);
    check_eq("reset_scnt",  64'(h_if.stall_cycle_count), 64'd0);
    @(posedge clock); #3 reset = 1'b1;

    idle(0, 0, 0, 2'd0);
    // load-use via rs1, then non-hazard variants
    step(5'd5, 5'd0, 1, 0, 5'd5, 1, 2'd0, 0, 0,  1, 0, 0, 2'd0);
    idle(0, 0, 0, 2'd0);
    step(5'd0, 5'd0, 1, 0, 5'd0, 1, 2'd0, 0, 0,  0, 0, 0, 2'd0);
    step(5'd5, 5'd0, 0, 0, 5'd5, 1, 2'd0, 0, 0,  0, 0, 0, 2'd0);
    step(5'd5, 5'd0, 1, 0, 5'd5, 0, 2'd0, 0, 0,  0, 0, 0, 2'd0);
    step(5'd1, 5'd9, 0, 1, 5'd9, 1, 2'd0, 0, 0,  1, 0, 0, 2'd0);
    // memory wait: 3 cycles not ready, then ready; redirect ignored meanwhile
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 0, 2'd0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 0, 2'd1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd1, 1, 0,  1, 1, 0, 2'd1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 1,  1, 1, 0, 2'd1);
    idle(0, 0, 0, 2'd0);
    // redirect: two flush cycles
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd1, 0, 0,  0, 0, 1, 2'd0);
    idle(0, 0, 1, 2'd2);
    idle(0, 0, 0, 2'd0);
    // redirect with simultaneous load-use: flush wins, no stall
    step(5'd7, 5'd0, 1, 0, 5'd7, 1, 2'd2, 0, 0,  0, 0, 1, 2'd0);
    idle(0, 0, 1, 2'd2);
    idle(0, 0, 0, 2'd0);
    // memory wait inside FLUSH holds the flush counter
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd3, 0, 0,  0, 0, 1, 2'd0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 1, 2'd2);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 1, 2'd2);
    idle(0, 0, 1, 2'd2);
    idle(0, 0, 0, 2'd0);
    // new redirect in FLUSH reloads; load-use there is ignored
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd1, 0, 0,  0, 0, 1, 2'd0);
    step(5'd3, 5'd0, 1, 0, 5'd3, 1, 2'd1, 0, 0,  0, 0, 1, 2'd2);
    idle(0, 0, 1, 2'd2);
    idle(0, 0, 0, 2'd0);
    // enter MEM_WAIT, then asynchronous reset between edges
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 0, 2'd0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 2'd0, 1, 0,  1, 1, 0, 2'd1);
    drain();
    reset = 1'b0;
    #1;
    check_eq("async_stall", 64'(h_if.stall_fetch), 64'd0);
    check_eq("async_hold",  64'(h_if.hold_execute_memory), 64'd0);
    check_eq("async_state", 64'(h_if.ctrl_state), 64'd0);
    check_eq("async_scnt",  64'(h_if.stall_cycle_count), 64'd0);
    check_eq("async_fcnt",  64'(h_if.flush_cycle_count), 64'd0);
    exp_scnt = 0;
    exp_fcnt = 0;
    h_if.memReq_memory = 1'b0;
    #2 reset = 1'b1;
    idle(0, 0, 0, 2'd0);
    idle(0, 0, 0, 2'd0);
    drain();

    // saturation on the 4-bit instance
    @(posedge clock); #1;
    s_if.memReq_memory = 1'b1;
    s_if.mem_ready     = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    check_eq("sat_count_14", 64'(s_if.stall_cycle_count), 64'd14);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check_eq("sat_count_20", 64'(s_if.stall_cycle_count), 64'd15);
    check_eq("sat_state",    64'(s_if.ctrl_state), 64'd1);
    check_eq("sat_hold",     64'(s_if.hold_execute_memory), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
